// File: rtl/csr_trap_ctrl_if.sv
// CSR register-file port: the trap sequencer is the master, the CSR file
// is the slave and answers reads combinationally in the same cycle.
interface csr_trap_ctrl_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
);
    logic [ADDRW-1:0] addr;
    logic             we;
    logic             re;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;

    modport master (
        output addr,
        output we,
        output re,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  we,
        input  re,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Trap sequencer: machine external interrupt entry and MRET return,
// sharing the CSR file port with the pipeline while idle.
module csr_trap_ctrl #(
    parameter int              DW           = 32,
    parameter int              ADDRW        = 12,
    parameter logic [ADDRW-1:0] MSTATUS_ADDR = 12'h300,
    parameter logic [ADDRW-1:0] MIE_ADDR     = 12'h304,
    parameter logic [ADDRW-1:0] MTVEC_ADDR   = 12'h305,
    parameter logic [ADDRW-1:0] MEPC_ADDR    = 12'h341,
    parameter logic [ADDRW-1:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [DW-1:0]    CAUSE_EXT    = 32'h8000000B
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             intr_i,
    input  logic             mret_i,
    input  logic [DW-1:0]    pc_i,
    input  logic             pc_valid_i,
    input  logic [ADDRW-1:0] pipe_addr_i,
    input  logic             pipe_we_i,
    input  logic             pipe_re_i,
    input  logic [DW-1:0]    pipe_wdata_i,
    csr_trap_ctrl_if.master  csr,
    output logic             busy_o,
    output logic             redirect_o,
    output logic [DW-1:0]    redirect_pc_o,
    output logic             flush_o
);

    typedef enum logic [2:0] {
        IDLE,
        T_MIE,
        T_STATUS,
        T_EPC,
        T_CAUSE,
        T_VEC,
        R_STATUS,
        R_EPC
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    epc_q, epc_d;

    logic [ADDRW-1:0] addr;
    logic             we;
    logic             re;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rd;
    logic             busy;
    logic             redir;
    logic [DW-1:0]    rpc;

    assign rd = csr.rdata;

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        addr    = '0;
        we      = 1'b0;
        re      = 1'b0;
        wdata   = '0;
        busy    = 1'b1;
        redir   = 1'b0;
        rpc     = '0;

        unique case (state_q)
            IDLE: begin
                busy  = 1'b0;
                addr  = pipe_addr_i;
                we    = pipe_we_i;
                re    = pipe_re_i;
                wdata = pipe_wdata_i;
                // MRET wins; a pending interrupt is resampled afterwards
                if (mret_i) begin
                    state_d = R_STATUS;
                end else if (intr_i && pc_valid_i) begin
                    epc_d   = pc_i;
                    state_d = T_MIE;
                end
            end
            T_MIE: begin
                addr    = MIE_ADDR;
                re      = 1'b1;
                state_d = rd[11] ? T_STATUS : IDLE;
            end
            T_STATUS: begin
                addr = MSTATUS_ADDR;
                re   = 1'b1;
                if (rd[3]) begin
                    we       = 1'b1;
                    wdata    = rd;
                    wdata[7] = rd[3];
                    wdata[3] = 1'b0;
                    state_d  = T_EPC;
                end else begin
                    state_d = IDLE;
                end
            end
            T_EPC: begin
                addr    = MEPC_ADDR;
                we      = 1'b1;
                wdata   = epc_q;
                state_d = T_CAUSE;
            end
            T_CAUSE: begin
                addr    = MCAUSE_ADDR;
                we      = 1'b1;
                wdata   = CAUSE_EXT;
                state_d = T_VEC;
            end
            T_VEC: begin
                addr    = MTVEC_ADDR;
                re      = 1'b1;
                redir   = 1'b1;
                rpc     = {rd[DW-1:2], 2'b00};
                state_d = IDLE;
            end
            R_STATUS: begin
                addr     = MSTATUS_ADDR;
                re       = 1'b1;
                we       = 1'b1;
                wdata    = rd;
                wdata[3] = rd[7];
                wdata[7] = 1'b1;
                state_d  = R_EPC;
            end
            R_EPC: begin
                addr    = MEPC_ADDR;
                re      = 1'b1;
                redir   = 1'b1;
                rpc     = {rd[DW-1:2], 2'b00};
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset mid-sequence must not leak a write or a redirect
        if (rst_i) begin
            addr  = pipe_addr_i;
            we    = pipe_we_i;
            re    = pipe_re_i;
            wdata = pipe_wdata_i;
            busy  = 1'b0;
            redir = 1'b0;
            rpc   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

    assign csr.addr      = addr;
    assign csr.we        = we;
    assign csr.re        = re;
    assign csr.wdata     = wdata;
    assign busy_o        = busy;
    assign redirect_o    = redir;
    assign flush_o       = redir;
    assign redirect_pc_o = rpc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: CSR file model, directed scenarios and random
// operations checked against an event-level trap/MRET reference model.
module tb_csr_trap_ctrl;

    localparam logic [11:0] A_MST   = 12'h300;
    localparam logic [11:0] A_MIE   = 12'h304;
    localparam logic [11:0] A_TVEC  = 12'h305;
    localparam logic [11:0] A_EPC   = 12'h341;
    localparam logic [11:0] A_CAUSE = 12'h342;
    localparam logic [31:0] CAUSE   = 32'h8000000B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        intr = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic [11:0] p_addr = '0;
    logic        p_we = 1'b0;
    logic        p_re = 1'b0;
    logic [31:0] p_wdata = '0;
    logic        busy, redirect, flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    csr_trap_ctrl_if csr_if ();

    csr_trap_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .intr_i       (intr),
        .mret_i       (mret),
        .pc_i         (pc),
        .pc_valid_i   (pc_valid),
        .pipe_addr_i  (p_addr),
        .pipe_we_i    (p_we),
        .pipe_re_i    (p_re),
        .pipe_wdata_i (p_wdata),
        .csr          (csr_if),
        .busy_o       (busy),
        .redirect_o   (redirect),
        .redirect_pc_o(redirect_pc),
        .flush_o      (flush)
    );

    logic [31:0] mem [0:4095] = '{default: 32'h0};
    assign csr_if.rdata = mem[csr_if.addr];
    always @(posedge clk) if (csr_if.we) mem[csr_if.addr] <= csr_if.wdata;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] m_mst = '0, m_mie = '0, m_tvec = '0, m_epc = '0, m_cause = '0;

    typedef struct packed {
        logic        busy;
        logic        redir;
        logic [31:0] pc;
    } cyc_t;
    cyc_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic void push_idle();
        exp_q.push_back('{1'b0, 1'b0, 32'h0});
    endfunction

    function automatic void push_intr(input logic [31:0] epc, input logic valid);
        if (!valid) begin
            push_idle();
        end else if (!m_mie[11]) begin
            exp_q.push_back('{1'b1, 1'b0, 32'h0});
        end else if (!m_mst[3]) begin
            repeat (2) exp_q.push_back('{1'b1, 1'b0, 32'h0});
        end else begin
            m_mst   = (m_mst & ~32'h8) | 32'h80;
            m_epc   = epc;
            m_cause = CAUSE;
            repeat (4) exp_q.push_back('{1'b1, 1'b0, 32'h0});
            exp_q.push_back('{1'b1, 1'b1, m_tvec & ~32'h3});
        end
    endfunction

    function automatic void push_mret();
        logic [31:0] tgt;
        tgt   = m_epc & ~32'h3;
        m_mst = (m_mst & ~32'h88) | ({31'b0, m_mst[7]} << 3) | 32'h80;
        exp_q.push_back('{1'b1, 1'b0, 32'h0});
        exp_q.push_back('{1'b1, 1'b1, tgt});
    endfunction

    // Called just after a posedge with the event inputs already driven
    task automatic run_trace(input int clr_intr_at);
        cyc_t e;
        int   n;
        n = exp_q.size();
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            #1;
            if (c == 1) mret = 1'b0;
            if (c == clr_intr_at) intr = 1'b0;
            @(negedge clk);
            e = exp_q[c-1];
            check($sformatf("busy c%0d", c), {31'b0, busy}, {31'b0, e.busy});
            check($sformatf("redir c%0d", c), {31'b0, redirect}, {31'b0, e.redir});
            check($sformatf("flush c%0d", c), {31'b0, flush}, {31'b0, e.redir});
            if (e.redir) check($sformatf("rpc c%0d", c), redirect_pc, e.pc);
            @(posedge clk);
        end
        #1;
        exp_q.delete();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        p_addr  = a;
        p_wdata = d;
        p_we    = 1'b1;
        @(negedge clk);
        check("wr busy", {31'b0, busy}, 32'h0);
        check("wr we", {31'b0, csr_if.we}, 32'h1);
        @(posedge clk);
        #1;
        p_we = 1'b0;
        unique case (a)
            A_MST:   m_mst = d;
            A_MIE:   m_mie = d;
            A_TVEC:  m_tvec = d;
            A_EPC:   m_epc = d;
            A_CAUSE: m_cause = d;
            default: ;
        endcase
    endtask

    task automatic chk_mem();
        check("mstatus", mem[A_MST], m_mst);
        check("mie", mem[A_MIE], m_mie);
        check("mtvec", mem[A_TVEC], m_tvec);
        check("mepc", mem[A_EPC], m_epc);
        check("mcause", mem[A_CAUSE], m_cause);
    endtask

    task automatic do_intr(input logic [31:0] p, input logic v);
        intr = 1'b1;
        pc = p;
        pc_valid = v;
        push_intr(p, v);
        run_trace(1);
    endtask

    task automatic do_mret();
        mret = 1'b1;
        push_mret();
        run_trace(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        logic [11:0] addrs [5];
        addrs = '{A_MST, A_MIE, A_TVEC, A_EPC, A_CAUSE};

        // Reset: no busy/redirect, CSR port passes the pipeline through
        p_addr  = 12'h7a5;
        p_re    = 1'b1;
        p_wdata = 32'hdeadbeef;
        intr    = 1'b1;
        pc_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'b0, busy}, 32'h0);
        check("rst redir", {31'b0, redirect}, 32'h0);
        check("rst flush", {31'b0, flush}, 32'h0);
        check("rst rpc", redirect_pc, 32'h0);
        check("rst addr", {20'b0, csr_if.addr}, 32'h7a5);
        check("rst re", {31'b0, csr_if.re}, 32'h1);
        check("rst wdata", csr_if.wdata, 32'hdeadbeef);
        @(posedge clk);
        #1;
        intr = 1'b0;
        p_re = 1'b0;
        rst  = 1'b0;

        // Full trap entry
        wr(A_MIE, 32'h800);
        wr(A_MST, 32'h8);
        wr(A_TVEC, 32'h100);
        do_intr(32'h40, 1'b1);
        check("t1 mstatus", mem[A_MST], 32'h80);
        check("t1 mepc", mem[A_EPC], 32'h40);
        check("t1 mcause", mem[A_CAUSE], CAUSE);
        chk_mem();

        // MRET return
        wr(A_EPC, 32'h44);
        do_mret();
        check("t2 mstatus", mem[A_MST], 32'h88);
        chk_mem();

        // Blocked entries
        wr(A_MIE, 32'h0);
        do_intr(32'h80, 1'b1);
        chk_mem();
        wr(A_MIE, 32'h800);
        wr(A_MST, 32'h0);
        do_intr(32'h84, 1'b1);
        chk_mem();

        // Simultaneous MRET and interrupt: MRET first, then entry
        wr(A_MST, 32'h80);
        mret = 1'b1;
        intr = 1'b1;
        pc = 32'h9c;
        pc_valid = 1'b1;
        push_mret();
        push_idle();
        push_intr(32'h9c, 1'b1);
        run_trace(4);
        check("t4 mepc", mem[A_EPC], 32'h9c);
        chk_mem();

        // Pass-through write to mtvec, then masked trap target
        wr(A_TVEC, 32'h200);
        chk_mem();
        wr(A_TVEC, 32'h203);
        wr(A_MST, 32'h8);
        do_intr(32'hc0, 1'b1);
        chk_mem();

        // Interrupt held high: re-entry blocked by cleared MIE
        wr(A_MST, 32'h8);
        intr = 1'b1;
        pc = 32'h140;
        pc_valid = 1'b1;
        push_intr(32'h140, 1'b1);
        push_idle();
        push_intr(32'h140, 1'b1);
        run_trace(7);
        chk_mem();

        // Reset during T_EPC
        wr(A_MST, 32'h8);
        wr(A_EPC, 32'h1234);
        wr(A_CAUSE, 32'h0);
        intr = 1'b1;
        pc = 32'h60;
        pc_valid = 1'b1;
        @(posedge clk);
        #1;
        intr = 1'b0;
        @(negedge clk);
        check("rm busy1", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rm busy2", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rm busy3", {31'b0, busy}, 32'h0);
        check("rm we3", {31'b0, csr_if.we}, 32'h0);
        check("rm redir3", {31'b0, redirect}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rm busy4", {31'b0, busy}, 32'h0);
        check("rm redir4", {31'b0, redirect}, 32'h0);
        @(posedge clk);
        #1;
        m_mst = 32'h80;
        check("rm mstatus", mem[A_MST], 32'h80);
        check("rm mcause", mem[A_CAUSE], 32'h0);
        chk_mem();

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            unique case (r)
                0: begin
                    int k;
                    k = $urandom_range(0, 4);
                    wr(addrs[k], $urandom);
                end
                1, 2: do_intr($urandom, ($urandom_range(0, 3) != 0));
                3: do_mret();
                default: begin
                    wr(A_MIE, $urandom | 32'h800);
                    wr(A_MST, $urandom | 32'h8);
                end
            endcase
            chk_mem();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
